mips_multicycle_control: RTL and testbench

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_pkg.sv | 88 ++++++++
 rtl/mips_multicycle_control_alu_decoder.sv | 26 ++
 rtl/mips_multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller, ALU and datapath:
// ALU control codes, opcode/funct constants, FSM state encoding and control bundle.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU B operand select: register, constant 4, sign-extended imm, imm << 2
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_write:    1'b0,
        i_or_d:      1'b0,
        mem_read:    1'b0,
        mem_write:   1'b0,
        ir_write:    1'b0,
        mem_to_reg:  1'b0,
        reg_dst:     1'b0,
        reg_write:   1'b0,
        alu_src_a:   1'b0,
        alu_src_b:   SRCB_REG,
        pc_source:   PCSRC_ALU,
        alu_control: ALU_ADD
    };

    function automatic logic opcode_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// R-type funct to ALU control mapping; unknown functs fall back to ADD and
// are flagged through funct_valid_o so the controller can trap them in DECODE.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_control_o,
    output logic       funct_valid_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        funct_valid_o = 1'b1;
        case (funct_i)
            FN_SLL:  alu_control_o = ALU_SLL;
            FN_ADD:  alu_control_o = ALU_ADD;
            FN_SUB:  alu_control_o = ALU_SUB;
            FN_AND:  alu_control_o = ALU_AND;
            FN_OR:   alu_control_o = ALU_OR;
            FN_NOR:  alu_control_o = ALU_NOR;
            FN_SLT:  alu_control_o = ALU_SLT;
            default: funct_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: Moore-decoded control FSM plus a
// retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction, PC <= PC + 4
// DECODE | register read, branch target into ALUOut, illegal trap
// MEMADR | lw/sw effective address
// MEMRD  | data memory read
// MEMWB  | load result to rt (final)
// MEMWR  | data memory write (final)
// EXEC   | R-type ALU operation
// ALUWB  | R-type result to rd (final)
// BRANCH | beq compare, PC <= target when zero (final)
// JUMP   | PC <= jump target (final)
// ADDIEX | addi ALU operation
// ADDIWB | addi result to rt (final)
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [3:0]  alu_control,
    output logic        illegal,
    output logic        instr_done,
    output logic [31:0] instr_count,
    output logic [3:0]  state
);

    state_e      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;
    ctrl_t       ctrl;
    logic        illegal_c;
    logic        done_c;
    logic [3:0]  funct_alu;
    logic        funct_valid;

    alu_decoder u_alu_decoder (
        .funct_i       (funct),
        .alu_control_o (funct_alu),
        .funct_valid_o (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        ctrl      = CTRL_IDLE;
        illegal_c = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = 1'b1;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_SHIMM;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_RTYPE:     state_d = funct_valid ? S_EXEC : S_FETCH;
                    default:      state_d = S_FETCH;
                endcase
                illegal_c = !opcode_supported(opcode) ||
                            ((opcode == OP_RTYPE) && !funct_valid);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                state_d       = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                done_c          = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                done_c         = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_REG;
                ctrl.alu_control = funct_alu;
                state_d          = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                done_c         = 1'b1;
            end
            S_BRANCH: begin
                // the one Mealy output: the taken decision comes straight from the ALU
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_REG;
                ctrl.alu_control = ALU_SUB;
                ctrl.pc_source   = PCSRC_ALUOUT;
                ctrl.pc_write    = zero;
                done_c           = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
                done_c         = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                done_c         = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        instr_count_d = instr_count_q;
        if (done_c) begin
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    // Reset overrides every strobe so nothing is written while the core is held.
    assign pc_write    = ctrl.pc_write   & ~reset;
    assign i_or_d      = ctrl.i_or_d     & ~reset;
    assign mem_read    = ctrl.mem_read   & ~reset;
    assign mem_write   = ctrl.mem_write  & ~reset;
    assign ir_write    = ctrl.ir_write   & ~reset;
    assign mem_to_reg  = ctrl.mem_to_reg & ~reset;
    assign reg_dst     = ctrl.reg_dst    & ~reset;
    assign reg_write   = ctrl.reg_write  & ~reset;
    assign alu_src_a   = ctrl.alu_src_a  & ~reset;
    assign alu_src_b   = reset ? SRCB_REG  : ctrl.alu_src_b;
    assign pc_source   = reset ? PCSRC_ALU : ctrl.pc_source;
    assign alu_control = reset ? ALU_ADD   : ctrl.alu_control;
    assign illegal     = illegal_c & ~reset;
    assign instr_done  = done_c & ~reset;
    assign instr_count = instr_count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized instruction stream against a per-instruction, per-step model of
// the controller's expected control outputs, state and retirement count.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        zero;
    logic        pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_source;
    logic [3:0]  alu_control;
    logic        illegal, instr_done;
    logic [31:0] instr_count;
    logic [3:0]  state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4,
                   K_J = 5, K_ILL_OP = 6, K_ILL_FN = 7;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .pc_write    (pc_write),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_source   (pc_source),
        .alu_control (alu_control),
        .illegal     (illegal),
        .instr_done  (instr_done),
        .instr_count (instr_count),
        .state       (state)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] dut_vec();
        return {pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, pc_source, alu_control, illegal, instr_done};
    endfunction

    function automatic logic fn_ok(input logic [5:0] fn);
        return fn == 6'h00 || fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
               fn == 6'h25 || fn == 6'h27 || fn == 6'h2A;
    endfunction

    function automatic logic op_ok(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h02 || op == 6'h08;
    endfunction

    function automatic logic [3:0] fn_alu(input logic [5:0] fn);
        case (fn)
            6'h00:   return 4'b0011;
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h27:   return 4'b1100;
            6'h2A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic int latency(input int kind);
        case (kind)
            K_LW:                 return 5;
            K_SW, K_R, K_ADDI:    return 4;
            K_BEQ, K_J:           return 3;
            default:              return 2;
        endcase
    endfunction

    // Expected behaviour of step s (0 = fetch cycle) of an instruction of class kind.
    task automatic model(input int kind, input int s, input logic [5:0] fn, input logic z,
                         output logic [3:0] st, output logic [18:0] v);
        logic pw, iod, mr, mw, irw, m2r, rd, rw, sa, ill, dn;
        logic [1:0] sb, ps;
        logic [3:0] ac;
        {pw, iod, mr, mw, irw, m2r, rd, rw, sa, ill, dn} = '0;
        sb = 2'b00; ps = 2'b00; ac = 4'b0010; st = 4'd0;
        if (s == 0) begin
            st = 4'd0; mr = 1; irw = 1; sb = 2'b01; pw = 1;
        end else if (s == 1) begin
            st = 4'd1; sb = 2'b11; ill = (kind == K_ILL_OP || kind == K_ILL_FN);
        end else begin
            case (kind)
                K_LW, K_SW: begin
                    if (s == 2) begin st = 4'd2; sa = 1; sb = 2'b10; end
                    else if (kind == K_SW) begin st = 4'd5; mw = 1; iod = 1; dn = 1; end
                    else if (s == 3) begin st = 4'd3; mr = 1; iod = 1; end
                    else begin st = 4'd4; rw = 1; m2r = 1; dn = 1; end
                end
                K_R: begin
                    if (s == 2) begin st = 4'd6; sa = 1; ac = fn_alu(fn); end
                    else begin st = 4'd7; rw = 1; rd = 1; dn = 1; end
                end
                K_ADDI: begin
                    if (s == 2) begin st = 4'd10; sa = 1; sb = 2'b10; end
                    else begin st = 4'd11; rw = 1; dn = 1; end
                end
                K_BEQ: begin st = 4'd8; sa = 1; ac = 4'b0110; ps = 2'b01; pw = z; dn = 1; end
                default: begin st = 4'd9; ps = 2'b10; pw = 1; dn = 1; end
            endcase
        end
        v = {pw, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ps, ac, ill, dn};
    endtask

    localparam logic [18:0] RESET_VEC = 19'b0000_0000_0000_0001_000;

    // Entered just after a falling edge with the DUT in FETCH; zmode<0 randomizes zero.
    task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                             input int zmode);
        logic [3:0]  est;
        logic [18:0] ev;
        opcode = op;
        funct  = fn;
        for (int s = 0; s < latency(kind); s++) begin
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            model(kind, s, fn, zero, est, ev);
            chk_eq($sformatf("state k%0d s%0d", kind, s), 32'(state), 32'(est));
            chk_eq($sformatf("ctrl k%0d s%0d", kind, s), 32'(dut_vec()), 32'(ev));
            if (ev[0]) exp_count = exp_count + 32'd1;
            @(negedge clk);
        end
        #1;
        chk_eq($sformatf("count k%0d", kind), instr_count, exp_count);
    endtask

    task automatic run_random();
        int          kind;
        logic [5:0]  op, fn;
        kind = $urandom_range(0, 7);
        fn   = 6'($urandom_range(0, 63));
        case (kind)
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            K_ADDI: op = 6'h08;
            K_BEQ:  op = 6'h04;
            K_J:    op = 6'h02;
            K_R: begin
                op = 6'h00;
                while (!fn_ok(fn)) fn = 6'($urandom_range(0, 63));
            end
            K_ILL_FN: begin
                op = 6'h00;
                while (fn_ok(fn)) fn = 6'($urandom_range(0, 63));
            end
            default: begin
                op = 6'($urandom_range(0, 63));
                while (op_ok(op)) op = 6'($urandom_range(0, 63));
            end
        endcase
        run_instr(kind, op, fn, -1);
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
        exp_count = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_eq("reset_ctrl", 32'(dut_vec()), 32'(RESET_VEC));
        chk_eq("reset_state", 32'(state), 32'd0);
        chk_eq("reset_count", instr_count, 32'd0);
        reset = 1'b0;

        run_instr(K_LW, 6'h23, 6'h00, -1);
        run_instr(K_R, 6'h00, 6'h2A, -1);
        run_instr(K_R, 6'h00, 6'h00, -1);
        run_instr(K_BEQ, 6'h04, 6'h11, 1);
        run_instr(K_BEQ, 6'h04, 6'h11, 0);
        run_instr(K_ILL_OP, 6'h3F, 6'h20, -1);
        run_instr(K_ILL_FN, 6'h00, 6'h08, -1);
        run_instr(K_SW, 6'h2B, 6'h00, -1);
        run_instr(K_ADDI, 6'h08, 6'h00, -1);
        run_instr(K_J, 6'h02, 6'h00, -1);
        for (int i = 0; i < 150; i++) run_random();

        // abandon a load in MEMRD
        opcode = 6'h23;
        repeat (3) @(negedge clk);
        #1;
        chk_eq("memrd_state", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        chk_eq("memrd_reset_ctrl", 32'(dut_vec()), 32'(RESET_VEC));
        @(negedge clk);
        reset = 1'b0;
        exp_count = 32'd0;
        #1;
        chk_eq("after_reset_state", 32'(state), 32'd0);
        chk_eq("after_reset_rw", 32'(reg_write), 32'd0);
        chk_eq("after_reset_count", instr_count, 32'd0);

        // counter wrap
        dut.instr_count_q = 32'hFFFF_FFFF;
        exp_count = 32'hFFFF_FFFF;
        run_instr(K_J, 6'h02, 6'h00, -1);
        chk_eq("wrap_count", instr_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
